// File: rtl/seg_capture_decoder_if.sv
// Snooped seven-segment display bus plus the recovered-digit outputs.
// The display driver (or its model) is the master; the capture decoder is the slave.
interface seg_capture_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [4*NUM_DIGITS-1:0] hex_out;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    frame_valid;

  modport master (
    output seg_n, an_n,
    input  hex_out, blank, digit_err, frame_valid
  );

  modport slave (
    input  seg_n, an_n,
    output hex_out, blank, digit_err, frame_valid
  );
endinterface

// File: rtl/seg_capture_decoder.sv
// Recovers hex digits from a multiplexed active-low seven-segment bus: synchronise,
// require a stable window per digit, inverse-decode, and strobe once per full frame.
module seg_capture_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  seg_capture_decoder_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_e;

  logic [6:0]              seg_meta_q, seg_sync_q, prev_seg_q;
  logic [NUM_DIGITS-1:0]   an_meta_q, an_sync_q, prev_an_q;
  logic [CW-1:0]           count_q, count_d;
  state_e                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    frame_q, frame_d;

  logic                    one_hot, same, capture;
  logic [IW-1:0]           dig_idx;
  logic [NUM_DIGITS-1:0]   seen_next;
  logic [4:0]              dec;

  // Returns {hit, nibble}; hit=0 for all-off and unmapped patterns.
  function automatic logic [4:0] inv_decode(input logic [6:0] seg);
    unique case (seg)
      7'h40:   return {1'b1, 4'h0};
      7'h79:   return {1'b1, 4'h1};
      7'h24:   return {1'b1, 4'h2};
      7'h30:   return {1'b1, 4'h3};
      7'h19:   return {1'b1, 4'h4};
      7'h12:   return {1'b1, 4'h5};
      7'h02:   return {1'b1, 4'h6};
      7'h78:   return {1'b1, 4'h7};
      7'h00:   return {1'b1, 4'h8};
      7'h10:   return {1'b1, 4'h9};
      7'h08:   return {1'b1, 4'hA};
      7'h03:   return {1'b1, 4'hB};
      7'h27:   return {1'b1, 4'hC};
      7'h21:   return {1'b1, 4'hD};
      7'h06:   return {1'b1, 4'hE};
      7'h0E:   return {1'b1, 4'hF};
      default: return 5'h00;
    endcase
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    state_d   = state_q;
    hex_d     = hex_q;
    blank_d   = blank_q;
    err_d     = err_q;
    seen_d    = seen_q;
    frame_d   = 1'b0;
    capture   = 1'b0;
    dig_idx   = '0;
    seen_next = seen_q;

    one_hot = $onehot(~an_sync_q);
    same    = (seg_sync_q == prev_seg_q) && (an_sync_q == prev_an_q);
    dec     = inv_decode(seg_sync_q);

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_sync_q[i]) dig_idx = IW'(i);
    end

    if (one_hot && same)
      count_d = (count_q == CW'(STABLE_CYCLES)) ? count_q : count_q + 1'b1;
    else
      count_d = '0;

    if (!one_hot) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  state_d = TRACK;
        TRACK: if (same && count_q == CW'(STABLE_CYCLES - 1)) begin
                 capture = 1'b1;
                 state_d = HELD;
               end
        HELD:  if (!same) state_d = TRACK;
        default: state_d = IDLE;
      endcase
    end

    if (capture) begin
      if (seg_sync_q == 7'h7F) begin
        blank_d[dig_idx] = 1'b1;
        err_d[dig_idx]   = 1'b0;
      end else if (dec[4]) begin
        hex_d[4*dig_idx +: 4] = dec[3:0];
        blank_d[dig_idx]      = 1'b0;
        err_d[dig_idx]        = 1'b0;
      end else begin
        blank_d[dig_idx] = 1'b0;
        err_d[dig_idx]   = 1'b1;
      end
      seen_next[dig_idx] = 1'b1;
      // A completed frame restarts collection from an empty mask.
      if (&seen_next) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d  = seen_next;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta_q <= '1;
      seg_sync_q <= '1;
      prev_seg_q <= '1;
      an_meta_q  <= '1;
      an_sync_q  <= '1;
      prev_an_q  <= '1;
      count_q    <= '0;
      state_q    <= IDLE;
      hex_q      <= '0;
      blank_q    <= '0;
      err_q      <= '0;
      seen_q     <= '0;
      frame_q    <= 1'b0;
    end else begin
      seg_meta_q <= bus.seg_n;
      seg_sync_q <= seg_meta_q;
      prev_seg_q <= seg_sync_q;
      an_meta_q  <= bus.an_n;
      an_sync_q  <= an_meta_q;
      prev_an_q  <= an_sync_q;
      count_q    <= count_d;
      state_q    <= state_d;
      hex_q      <= hex_d;
      blank_q    <= blank_d;
      err_q      <= err_d;
      seen_q     <= seen_d;
      frame_q    <= frame_d;
    end
  end

  assign bus.hex_out     = hex_q;
  assign bus.blank       = blank_q;
  assign bus.digit_err   = err_q;
  assign bus.frame_valid = frame_q;
endmodule

// File: tb/tb_seg_capture_decoder.sv
// Directed bench for seg_capture_decoder: expected frames are queued as the scan is
// driven and popped whenever the decoder strobes frame_valid.
module tb_seg_capture_decoder;
  localparam int ND = 4;
  localparam int SC = 8;

  typedef struct {
    logic [15:0] hex;
    logic [3:0]  blank;
    logic [3:0]  err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   since_apply = 0;
  exp_t sb[$];

  seg_capture_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seg_capture_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg);
    bus.an_n    = an;
    bus.seg_n   = seg;
    since_apply = 0;
  endtask

  // One clock; outputs sampled on the falling edge, frames checked against the queue.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    since_apply++;
    if (bus.frame_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("frame_hex", 32'(bus.hex_out), 32'(e.hex));
        check("frame_blank", 32'(bus.blank), 32'(e.blank));
        check("frame_err", 32'(bus.digit_err), 32'(e.err));
        if (e.lat >= 0) check("frame_latency", 32'(since_apply - 1), 32'(e.lat));
      end
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_frame(input logic [15:0] hex, input logic [3:0] blank,
                              input logic [3:0] err, input int lat);
    exp_t e;
    e.hex = hex; e.blank = blank; e.err = err; e.lat = lat;
    sb.push_back(e);
  endtask

  initial begin
    // Reset with an idle bus
    rst_n = 1'b0;
    drive(4'hF, 7'h7F);
    hold(4);
    @(negedge clk);
    rst_n = 1'b1;
    hold(20);
    check("reset_hex", 32'(bus.hex_out), 32'h0);
    check("reset_blank", 32'(bus.blank), 32'h0);
    check("reset_err", 32'(bus.digit_err), 32'h0);
    check("reset_frame", 32'(bus.frame_valid), 32'h0);

    // Full scan: 2,3,4,A with frame 10 edges after the last anode is applied
    drive(4'b1110, 7'h24); hold(16);
    drive(4'b1101, 7'h30); hold(16);
    drive(4'b1011, 7'h19); hold(16);
    expect_frame(16'hA432, 4'h0, 4'h0, 2 + SC);
    drive(4'b0111, 7'h08); hold(16);
    check("scan_hex", 32'(bus.hex_out), 32'hA432);

    // Too-short hold never captures
    drive(4'b1110, 7'h79); hold(5);
    drive(4'hF, 7'h7F);    hold(16);
    check("short_hold_d0", 32'(bus.hex_out[3:0]), 32'h2);

    // Unmapped pattern flags an error, then a valid one clears it
    drive(4'b1101, 7'h7E); hold(16);
    check("unmapped_err", 32'(bus.digit_err), 32'b0010);
    check("unmapped_nib", 32'(bus.hex_out[7:4]), 32'h3);
    drive(4'b1101, 7'h0E); hold(16);
    check("remap_err", 32'(bus.digit_err), 32'b0000);
    check("remap_nib", 32'(bus.hex_out[7:4]), 32'hF);

    // Blank digit, then two anodes at once must not capture
    drive(4'b1011, 7'h7F); hold(16);
    check("blank_d2", 32'(bus.blank), 32'b0100);
    drive(4'b1001, 7'h24); hold(20);
    check("multi_an_blank", 32'(bus.blank), 32'b0100);
    check("multi_an_hex", 32'(bus.hex_out), 32'hA4F2);

    // Digits 1 and 2 already seen; completing 0 and 3 finishes the frame
    drive(4'b1110, 7'h40); hold(16);
    expect_frame(16'h54F0, 4'b0100, 4'h0, 2 + SC);
    drive(4'b0111, 7'h12); hold(16);

    // Partial frame, then asynchronous reset mid-hold of digit 3
    drive(4'b1110, 7'h02); hold(16);
    drive(4'b1101, 7'h00); hold(16);
    drive(4'b1011, 7'h78); hold(16);
    drive(4'b0111, 7'h10); hold(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_hex", 32'(bus.hex_out), 32'h0);
    check("async_rst_blank", 32'(bus.blank), 32'h0);
    check("async_rst_err", 32'(bus.digit_err), 32'h0);
    check("async_rst_frame", 32'(bus.frame_valid), 32'h0);
    @(negedge clk);
    drive(4'hF, 7'h7F);
    rst_n = 1'b1;
    hold(4);

    // Fresh full scan after reset yields exactly one frame
    drive(4'b1110, 7'h03); hold(16);
    drive(4'b1101, 7'h27); hold(16);
    drive(4'b1011, 7'h21); hold(16);
    expect_frame(16'hEDCB, 4'h0, 4'h0, 2 + SC);
    drive(4'b0111, 7'h06); hold(16);
    drive(4'hF, 7'h7F);    hold(10);

    check("all_frames_seen", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
